// File: rtl/vrf_wb_seq_if.sv
// Result-group input and VRF write-port bundle for vrf_wb_seq.
interface vrf_wb_seq_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_NUM    = 32,
   parameter int unsigned LANES      = 4
);
   localparam int unsigned ADDR_B = $clog2(REG_NUM);
   localparam int unsigned ELEM_B = $clog2(LANES);

   logic                          res_valid_i;
   logic                          res_ready_o;
   logic [LANES*DATA_WIDTH-1:0]   res_data_i;
   logic [LANES-1:0]              res_mask_i;
   logic [ADDR_B-1:0]             res_vd_i;
   logic                          wr_req_o;
   logic                          wr_en_o;
   logic                          wr_ready_o;
   logic [ADDR_B-1:0]             wr_addr_o;
   logic [ELEM_B-1:0]             wr_elem_cnt_o;
   logic [DATA_WIDTH-1:0]         wdata_o;
   logic                          busy_o;

   // Producer of result groups / consumer of VRF writes.
   modport master (
      output res_valid_i, res_data_i, res_mask_i, res_vd_i,
      input  res_ready_o, wr_req_o, wr_en_o, wr_ready_o, wr_addr_o,
      input  wr_elem_cnt_o, wdata_o, busy_o
   );

   // Write-back sequencer side.
   modport slave (
      input  res_valid_i, res_data_i, res_mask_i, res_vd_i,
      output res_ready_o, wr_req_o, wr_en_o, wr_ready_o, wr_addr_o,
      output wr_elem_cnt_o, wdata_o, busy_o
   );
endinterface

// File: rtl/vrf_wb_seq.sv
// Vector register file write-back sequencer: buffers lane result groups in a
// 2-entry FIFO and serialises each group into one request plus LANES element writes.
module vrf_wb_seq #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned REG_NUM    = 32,
   parameter int unsigned LANES      = 4
) (
   input  logic         clk_i,
   input  logic         reset_i,
   vrf_wb_seq_if.slave  bus
);
   localparam int unsigned ADDR_B = $clog2(REG_NUM);
   localparam int unsigned ELEM_B = $clog2(LANES);

   typedef struct packed {
      logic [LANES*DATA_WIDTH-1:0] data;
      logic [LANES-1:0]            mask;
      logic [ADDR_B-1:0]           vd;
   } entry_t;

   typedef enum logic [1:0] {IDLE, REQ, WRITE} state_t;

   state_t              state;
   state_t              state_next;
   entry_t              fifo [2];
   entry_t              head;
   logic                wr_ptr;
   logic                rd_ptr;
   logic [1:0]          count;
   logic [1:0]          count_next;
   logic [ELEM_B-1:0]   elem;
   logic                push;
   logic                pop;
   logic                last_elem;
   logic                wr_req;
   logic                wr_en;
   logic                wr_ready;
   logic [ELEM_B-1:0]   elem_out;
   logic [DATA_WIDTH-1:0] wdata;

   // FIFO handshake and occupancy bookkeeping.
   always_comb begin
      push       = bus.res_valid_i && (count < 2'd2);
      last_elem  = (elem == ELEM_B'(LANES - 1));
      pop        = (state == WRITE) && last_elem;
      count_next = count + {1'b0, push} - {1'b0, pop};
      head       = fifo[rd_ptr];
   end

   // FIFO storage, pointers and count.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < 2; i++) fifo[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            fifo[wr_ptr] <= '{data: bus.res_data_i, mask: bus.res_mask_i, vd: bus.res_vd_i};
            wr_ptr       <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count_next;
      end
   end

   // State register and element counter (cleared in REQ, stepped in WRITE).
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= IDLE;
         elem  <= '0;
      end else begin
         state <= state_next;
         if (state == REQ)        elem <= '0;
         else if (state == WRITE) elem <= elem + ELEM_B'(1);
      end
   end

   // Next-state and write-port decode; the last element pops and chains straight into REQ.
   always_comb begin
      state_next = state;
      wr_req     = 1'b0;
      wr_en      = 1'b0;
      wr_ready   = 1'b0;
      elem_out   = '0;
      wdata      = '0;
      case (state)
         IDLE: begin
            if (count != 2'd0) state_next = REQ;
         end
         REQ: begin
            wr_req     = 1'b1;
            state_next = WRITE;
         end
         WRITE: begin
            elem_out = elem;
            wdata    = head.data[elem*DATA_WIDTH +: DATA_WIDTH];
            wr_en    = head.mask[elem];
            if (last_elem) begin
               wr_ready   = 1'b1;
               state_next = (count_next != 2'd0) ? REQ : IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are decoded from registered state only.
   assign bus.res_ready_o   = (count < 2'd2);
   assign bus.wr_req_o      = wr_req;
   assign bus.wr_en_o       = wr_en;
   assign bus.wr_ready_o    = wr_ready;
   assign bus.wr_addr_o     = head.vd;
   assign bus.wr_elem_cnt_o = elem_out;
   assign bus.wdata_o       = wdata;
   assign bus.busy_o        = (state != IDLE) || (count != 2'd0);
endmodule

// File: tb/tb_vrf_wb_seq.sv
// Self-checking bench for vrf_wb_seq: table vectors, corner sequences and
// random traffic against a timeline model of group acceptance and scheduling.
module tb_vrf_wb_seq;
   localparam int unsigned DW = 32;
   localparam int unsigned RN = 32;
   localparam int unsigned LN = 4;
   localparam int unsigned AB = $clog2(RN);
   localparam int unsigned EB = $clog2(LN);

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   vrf_wb_seq_if #(.DATA_WIDTH(DW), .REG_NUM(RN), .LANES(LN)) bus ();

   vrf_wb_seq #(.DATA_WIDTH(DW), .REG_NUM(RN), .LANES(LN)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus.slave)
   );

   // Each accepted group: acceptance cycle, REQ cycle, payload. It occupies
   // cycles start..start+LN on the write port and leaves the buffer after start+LN.
   typedef struct {
      int                 acc;
      int                 start;
      logic [LN*DW-1:0]   data;
      logic [LN-1:0]      mask;
      logic [AB-1:0]      vd;
   } grp_t;

   typedef struct {
      logic [AB-1:0]      vd;
      logic [LN*DW-1:0]   data;
      logic [LN-1:0]      mask;
      logic [LN-1:0]      exp_en;
      logic [LN-1:0]      exp_rdy;
   } vec_t;

   grp_t gq[$];
   int   cyc;
   int   last_end;
   int   checks;
   int   errors;
   int   req_cnt, first_req, last_rdy, first_rdy;

   logic          o_req, o_en, o_rdy, o_ready, o_busy;
   logic [AB-1:0] o_addr;
   logic [EB-1:0] o_elem;
   logic [DW-1:0] o_wdata;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      gq.delete();
      last_end = -100;
   endtask

   // Compare this cycle's outputs with the timeline, then record any acceptance.
   task automatic model_check(input bit v, input logic [LN*DW-1:0] d,
                              input logic [LN-1:0] m, input logic [AB-1:0] vd);
      int            cnt;
      int            gi;
      int            ph;
      logic          e_req, e_en, e_rdy;
      logic [EB-1:0] e_elem;
      logic [DW-1:0] e_wd;
      grp_t          g;
      cnt = 0; gi = -1;
      e_req = 1'b0; e_en = 1'b0; e_rdy = 1'b0; e_elem = '0; e_wd = '0;
      while (gq.size() > 0 && gq[0].start + int'(LN) < cyc) void'(gq.pop_front());
      foreach (gq[i]) begin
         if (gq[i].acc < cyc && gq[i].start + int'(LN) >= cyc) cnt++;
         if (gq[i].start <= cyc && cyc <= gq[i].start + int'(LN)) gi = i;
      end
      if (gi >= 0) begin
         ph    = cyc - gq[gi].start;
         e_req = (ph == 0);
         e_rdy = (ph == int'(LN));
         if (ph > 0) begin
            e_elem = EB'(ph - 1);
            e_en   = gq[gi].mask[ph-1];
            e_wd   = gq[gi].data[(ph-1)*DW +: DW];
         end
         chk("m_addr", o_addr, gq[gi].vd);
      end
      chk("m_req", o_req, e_req);
      chk("m_en", o_en, e_en);
      chk("m_rdy", o_rdy, e_rdy);
      chk("m_elem", o_elem, e_elem);
      chk("m_wdata", o_wdata, e_wd);
      chk("m_res_ready", o_ready, (cnt < 2));
      chk("m_busy", o_busy, (gi >= 0) || (cnt != 0));
      if (v && cnt < 2) begin
         g.acc   = cyc;
         g.start = (cyc <= last_end) ? last_end + 1 : cyc + 2;
         g.data  = d;
         g.mask  = m;
         g.vd    = vd;
         last_end = g.start + int'(LN);
         gq.push_back(g);
      end
   endtask

   // One clock cycle: drive, sample at the falling edge, check, advance.
   task automatic step(input bit v, input logic [LN*DW-1:0] d,
                       input logic [LN-1:0] m, input logic [AB-1:0] vd);
      bus.res_valid_i = v;
      bus.res_data_i  = d;
      bus.res_mask_i  = m;
      bus.res_vd_i    = vd;
      @(negedge clk);
      o_req   = bus.wr_req_o;
      o_en    = bus.wr_en_o;
      o_rdy   = bus.wr_ready_o;
      o_ready = bus.res_ready_o;
      o_busy  = bus.busy_o;
      o_addr  = bus.wr_addr_o;
      o_elem  = bus.wr_elem_cnt_o;
      o_wdata = bus.wdata_o;
      if (o_req) begin
         req_cnt++;
         if (first_req < 0) first_req = cyc;
      end
      if (o_rdy) begin
         last_rdy = cyc;
         if (first_rdy < 0) first_rdy = cyc;
      end
      model_check(v, d, m, vd);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0);
   endtask

   task automatic chk_reset_vals(input string p);
      chk({p, "_wr_req"}, bus.wr_req_o, 0);
      chk({p, "_wr_en"}, bus.wr_en_o, 0);
      chk({p, "_wr_ready"}, bus.wr_ready_o, 0);
      chk({p, "_elem"}, bus.wr_elem_cnt_o, 0);
      chk({p, "_addr"}, bus.wr_addr_o, 0);
      chk({p, "_wdata"}, bus.wdata_o, 0);
      chk({p, "_busy"}, bus.busy_o, 0);
      chk({p, "_res_ready"}, bus.res_ready_o, 1);
   endtask

   function automatic logic [LN*DW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl [4];
      int   wait_c, data_bad, addr_bad, acc, third_acc, en_cnt;
      logic [LN-1:0] en_seen, rdy_seen;
      logic [LN*DW-1:0] rd;

      checks = 0; errors = 0; cyc = 0;
      req_cnt = 0; first_req = -1; last_rdy = -1; first_rdy = -1;
      model_reset();

      tbl[0] = '{vd: 5'd5,  data: {32'hA3, 32'hA2, 32'hA1, 32'hA0}, mask: 4'b1111, exp_en: 4'b1111, exp_rdy: 4'b1000};
      tbl[1] = '{vd: 5'd9,  data: {32'hB3, 32'hB2, 32'hB1, 32'hB0}, mask: 4'b0101, exp_en: 4'b0101, exp_rdy: 4'b1000};
      tbl[2] = '{vd: 5'd17, data: {32'hC3, 32'hC2, 32'hC1, 32'hC0}, mask: 4'b0000, exp_en: 4'b0000, exp_rdy: 4'b1000};
      tbl[3] = '{vd: 5'd31, data: {32'hFFFF_FFFF, 32'h0, 32'h1234_5678, 32'hDEAD_BEEF}, mask: 4'b1010, exp_en: 4'b1010, exp_rdy: 4'b1000};

      // Reset values while reset is held.
      rst = 1'b1;
      bus.res_valid_i = 1'b0;
      bus.res_data_i  = '0;
      bus.res_mask_i  = '0;
      bus.res_vd_i    = '0;
      #3;
      chk_reset_vals("rst");
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // Isolated groups from the table: latency, strobes, data, address.
      for (int t = 0; t < 4; t++) begin
         step(1'b1, tbl[t].data, tbl[t].mask, tbl[t].vd);
         wait_c = 0;
         do begin
            idle(1);
            wait_c++;
         end while (!o_req && wait_c < 8);
         chk("tbl_req_latency", wait_c, 2);
         chk("tbl_req_addr", o_addr, tbl[t].vd);
         en_seen = '0; rdy_seen = '0; data_bad = 0; addr_bad = 0;
         for (int k = 0; k < int'(LN); k++) begin
            idle(1);
            en_seen[k]  = o_en;
            rdy_seen[k] = o_rdy;
            if (o_wdata !== tbl[t].data[k*DW +: DW]) data_bad++;
            if (o_addr !== tbl[t].vd) addr_bad++;
         end
         chk("tbl_en_pattern", en_seen, tbl[t].exp_en);
         chk("tbl_ready_pattern", rdy_seen, tbl[t].exp_rdy);
         chk("tbl_wdata_bad", data_bad, 0);
         chk("tbl_addr_bad", addr_bad, 0);
         idle(1);
         chk("tbl_busy_after", o_busy, 0);
      end

      // Three groups with valid held high: back-pressure and gapless output.
      req_cnt = 0; first_req = -1; last_rdy = -1; first_rdy = -1;
      acc = 0; third_acc = -1;
      for (int i = 0; i < 20 && acc < 3; i++) begin
         step(1'b1, rnd_data(), 4'($urandom), AB'($urandom));
         if (o_ready) begin
            acc++;
            if (acc == 3) third_acc = cyc - 1;
         end
      end
      chk("b2b_accepts", acc, 3);
      chk("b2b_ready_back", third_acc - first_rdy, 1);
      idle(12);
      chk("b2b_req_count", req_cnt, 3);
      chk("b2b_span", last_rdy - first_req + 1, 15);
      idle(2);

      // Push on the pop cycle with one group buffered.
      rd = rnd_data();
      step(1'b1, rd, 4'b1111, 5'd3);
      idle(5);
      step(1'b1, rnd_data(), 4'b0110, 5'd12);
      chk("pushpop_wr_ready", o_rdy, 1);
      chk("pushpop_res_ready", o_ready, 1);
      idle(1);
      chk("pushpop_next_req", o_req, 1);
      chk("pushpop_next_addr", o_addr, 5'd12);
      idle(6);

      // Reset pulsed during WRITE element 2.
      step(1'b1, rnd_data(), 4'b1111, 5'd21);
      idle(4);
      @(negedge clk);
      chk("midrst_pre_elem", bus.wr_elem_cnt_o, 2);
      chk("midrst_pre_en", bus.wr_en_o, 1);
      rst = 1'b1;
      #1;
      chk_reset_vals("midrst");
      @(posedge clk);
      #1;
      rst = 1'b0;
      cyc++;
      model_reset();
      en_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         idle(1);
         if (o_en) en_cnt++;
      end
      chk("midrst_no_strobes", en_cnt, 0);

      // Random traffic against the timeline model.
      for (int i = 0; i < 400; i++)
         step(($urandom % 4) != 0, rnd_data(), 4'($urandom), AB'($urandom));
      idle(12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vrf_wb_seq.md
VRF_WB_SEQ -- requirements
Module: vrf_wb_seq

Interface
REQ-001 The block SHALL have one clock, clk_i, and an asynchronous, active-high reset, reset_i.
REQ-002 Parameter DATA_WIDTH, 32, element width in bits.
REQ-003 Parameter REG_NUM, 32, number of vector registers; ADDR_B = clog2(REG_NUM).
REQ-004 Parameter LANES, 4, number of lanes; ELEM_B = clog2(LANES).
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 reset_i  in  1  asynchronous active-high reset.
REQ-007 res_valid_i  in  1  lane result group valid.
REQ-008 res_ready_o  out  1  result buffer can accept a group.
REQ-009 res_data_i  in  LANES*DATA_WIDTH  lane results; lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 res_mask_i  in  LANES  per-lane write enable; 1 = write.
REQ-011 res_vd_i  in  ADDR_B  destination vector register.
REQ-012 wr_req_o  out  1  write request to the VRF.
REQ-013 wr_en_o  out  1  element write strobe to the VRF.
REQ-014 wr_ready_o  out  1  last element of the group is being presented.
REQ-015 wr_addr_o  out  ADDR_B  destination register of the head group.
REQ-016 wr_elem_cnt_o  out  ELEM_B  lane/bank index of the current element.
REQ-017 wdata_o  out  DATA_WIDTH  current element data.
REQ-018 busy_o  out  1  buffer is non-empty or a transfer is in progress.

Function
REQ-019 The block SHALL hold a 2-entry FIFO; each entry SHALL contain {data, mask, vd}.
REQ-020 res_ready_o SHALL be 1 exactly when the FIFO count is less than 2, using the registered count with no same-cycle pop bypass.
REQ-021 A push SHALL occur on each cycle where res_valid_i && res_ready_o.
REQ-022 A pop SHALL occur in the cycle where wr_ready_o is 1; a simultaneous push and pop SHALL leave the count unchanged.
REQ-023 The FSM SHALL have states IDLE, REQ and WRITE.
REQ-024 IDLE: next = REQ if the registered count is greater than 0, otherwise IDLE.
REQ-025 REQ: wr_req_o = 1 for exactly one cycle; the element counter is cleared to 0; next = WRITE.
REQ-026 WRITE: wr_elem_cnt_o = counter; wdata_o = head lane[counter]; wr_en_o = head mask[counter]; the counter increments each cycle.
REQ-027 WRITE with counter == LANES-1: wr_ready_o = 1, pop; next = REQ if the post-pop count is greater than 0, otherwise IDLE.
REQ-028 Group latency SHALL be LANES+1 cycles (REQ plus LANES WRITE cycles); back-to-back groups SHALL have no idle cycle between them.
REQ-029 Masked lanes (mask = 0) SHALL still consume their WRITE cycle with wr_en_o = 0; an all-zero mask group SHALL still run the full sequence.
REQ-030 wr_en_o and wr_ready_o SHALL be 0 outside WRITE; wr_req_o SHALL be 0 outside REQ.
REQ-031 wr_addr_o SHALL equal the head vd, held constant from REQ through the last WRITE cycle.
REQ-032 A group pushed while the FIFO is empty and the FSM is IDLE SHALL reach REQ on the cycle after the push edge.
REQ-033 res_valid_i while the FIFO is full SHALL be ignored; the input data is not stored.
REQ-034 busy_o = (state != IDLE) || (count != 0).

Reset
REQ-035 While reset_i = 1 the block SHALL set state = IDLE, count = 0, FIFO pointers = 0, element counter = 0, and FIFO storage = 0.
REQ-036 Reset output values SHALL be: wr_req_o = 0, wr_en_o = 0, wr_ready_o = 0, wr_elem_cnt_o = 0, wr_addr_o = 0, wdata_o = 0, busy_o = 0, res_ready_o = 1.
REQ-037 Reset asserted mid-transfer SHALL discard all buffered groups and produce no further write strobes.

Verification
REQ-038 Single group, vd = 5, data lanes {0xA0, 0xA1, 0xA2, 0xA3}, mask 4'b1111 -> one wr_req_o cycle, then 4 cycles with wr_en_o = 1, elem 0..3, wdata 0xA0..0xA3, wr_addr_o = 5, wr_ready_o = 1 on elem 3 only.
REQ-039 Mask 4'b0101 -> wr_en_o = 1 on elem 0 and elem 2 only; 4 WRITE cycles still occur.
REQ-040 Three groups presented back-to-back with res_valid_i held at 1 -> res_ready_o drops after the 2nd accept and reasserts the cycle after the first wr_ready_o; the output is 3 x 5 cycles with no gap.
REQ-041 Push coinciding with the pop cycle while count = 1 -> count stays 1, and the next REQ occurs on the following cycle.
REQ-042 reset_i pulsed during WRITE elem 2 -> all outputs return to their reset values immediately, and no wr_en_o appears afterwards until a new push.
REQ-043 All-zero mask group -> 5-cycle sequence, wr_en_o = 0 throughout, and wr_ready_o = 1 on elem 3.
